cnt_multi_ctrl: RTL
===================

// Module: cnt_multi_ctrl
// PURPOSE
// - N-channel counter block with built-in control/status registers on a simple register bus.
// - Each channel: WIDTH-bit up-counter, enable, self-clearing clear, threshold,
//   free-run/one-shot mode, sticky terminal-count (TC) flag, TC pulse, per-channel IRQ enable.
// - Sits as a memory-mapped peripheral: register bus from the host, irq_o to the interrupt controller.
// PARAMETERS
// - NCH    4   number of counter channels (1..16)
// - WIDTH 32   counter/threshold width in bits (1..32)
// - ADDR_W 8   register address width in bits; must satisfy 16*NCH+4 <= 2**ADDR_W
// PORTS
// - clk_i        in   1       clock
// - rst_ni       in   1       async active-low reset
// - reg_valid_i  in   1       bus request valid
// - reg_write_i  in   1       1 = write, 0 = read
// - reg_addr_i   in   ADDR_W  byte address; bits [1:0] ignored
// - reg_wdata_i  in   32      write data
// - reg_wstrb_i  in   4       byte strobes
// - reg_rdata_o  out  32      read data, valid while reg_valid_i && reg_ready_o
// - reg_ready_o  out  1       tied 1 (single-cycle access)
// - reg_error_o  out  1       1 for an unmapped address while reg_valid_i
// - cnt_value_o  out  NCH*WIDTH  counter values, channel c at [c*WIDTH +: WIDTH]
// - tc_pulse_o   out  NCH     1-cycle pulse per TC event
// - irq_o        out  1       level IRQ = |(tc_q & irq_en_q)
// BEHAVIOUR
// - Reset (rst_ni=0, async): every counter=0; en, mode, irq_en, tc=0; thr=all ones;
//   tc_pulse_o=0; irq_o=0; reg_rdata_o=0; reg_error_o=0.
// - Map (channel c, base 16*c):
//   - +0x0 CTRL: [0]=EN, [1]=CLR (write-1 pulse, reads 0), [2]=ONESHOT, [3]=IRQ_EN.
//   - +0x4 THR: WIDTH bits.
//   - +0x8 VALUE: read-only.
//   - +0xC STATUS: [0]=TC, write-1-to-clear.
//   - 16*NCH: IRQ_STATUS, read-only, bit c = tc_q[c]&irq_en_q[c].
//   - Anything else: error=1, rdata=0, no side effects. Writes to read-only registers are ignored, no error.
// - Byte strobes: THR honours all wstrb bits. CTRL and STATUS update only when wstrb[0]=1.
//   Upper read bits are 0.
// - Reads are combinational from the current register state in the same cycle.
//   Writes take effect at the next clock edge.
// - Counter update each edge, priority high->low:
//   1. CLR write: value<=0, tc<=0, no pulse. EN/ONESHOT/IRQ_EN take the written bits.
//   2. en_q && value==thr (TC event): tc<=1; tc_pulse<=1 for one cycle.
//      - Free-run: value<=0.
//      - One-shot: value holds, en_q<=0. A same-cycle software CTRL write wins over this hardware clear.
//   3. en_q: value<=value+1, modulo 2**WIDTH (wraps past all ones, e.g. thr written below the current value).
//   4. Otherwise hold.
// - Latency: EN write in cycle t -> en_q=1 at t+1 -> first increment visible at t+2.
//   TC is reached thr+1 enabled edges after value=0. thr=0 gives TC on every enabled edge.
// - STATUS W1C in the same cycle as a TC event: set wins (tc stays 1).
// - irq_o is derived combinationally from registered tc_q/irq_en_q (glitch-free).
//   It is 1 in the cycle after the TC edge when IRQ_EN=1. Clearing IRQ_EN masks irq_o but keeps TC.
// - Mid-operation reset: all state returns to reset values immediately; no pulse is emitted.
// TESTING
// - Reset with bus idle -> all reads 0 except THR=2**WIDTH-1; irq_o=0; VALUE reads 0.
// - ch0: THR=3, CTRL=0x1 (free-run) -> value sequence 0,1,2,3,0,1; tc_pulse_o[0] one cycle after each 3;
//   STATUS=1; irq_o=0.
// - ch1: THR=2, CTRL=0xD (one-shot, IRQ_EN) -> stops at 2, CTRL reads 0xC, irq_o=1.
//   STATUS write 1 -> irq_o=0 next cycle.
// - ch0 running, W1C STATUS in the same cycle as a TC event -> TC stays 1.
//   CTRL=0x3 (CLR+EN) -> value=0, TC=0, keeps counting.
// - WIDTH=4: THR=2, let value reach 2, then THR=1 before the TC edge -> value wraps 15->0, then TC at 1.
// - Read addr 16*NCH+8 -> reg_error_o=1, rdata=0. THR write with wstrb=4'b0010, data 0xAABBCCDD
//   -> only byte 1 becomes 0xCC.

Source files
------------

// File: rtl/cnt_multi_ctrl.sv
// ============================================================================
// cnt_multi_ctrl : N-channel threshold counters with memory-mapped CSRs
// Rev 1.0
// ============================================================================
`default_nettype none

module cnt_multi_ctrl #(
  parameter int NCH    = 4,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 reg_valid_i,
  input  logic                 reg_write_i,
  input  logic [ADDR_W-1:0]    reg_addr_i,
  input  logic [31:0]          reg_wdata_i,
  input  logic [3:0]           reg_wstrb_i,
  output logic [31:0]          reg_rdata_o,
  output logic                 reg_ready_o,
  output logic                 reg_error_o,
  output logic [NCH*WIDTH-1:0] cnt_value_o,
  output logic [NCH-1:0]       tc_pulse_o,
  output logic                 irq_o
);

  localparam int              WA         = ADDR_W - 2;
  localparam logic [WA-1:0]   IRQ_WORD   = WA'(4 * NCH);
  localparam logic [1:0]      OFF_CTRL   = 2'd0;
  localparam logic [1:0]      OFF_THR    = 2'd1;
  localparam logic [1:0]      OFF_VALUE  = 2'd2;
  localparam logic [1:0]      OFF_STATUS = 2'd3;

  logic [NCH-1:0][WIDTH-1:0] value_q, value_d, thr_q, thr_d;
  logic [NCH-1:0] en_q, en_d, os_q, os_d, ie_q, ie_d, tc_q, tc_d, pulse_q, pulse_d;

  logic [WA-1:0]  w_word;
  logic [1:0]     w_off;
  logic           w_in_ch, w_is_irq, w_wr;
  logic [NCH-1:0] w_sel, w_ctrl_wr, w_thr_wr, w_w1c, w_hit;

  assign w_word   = reg_addr_i[ADDR_W-1:2];
  assign w_off    = w_word[1:0];
  assign w_in_ch  = (w_word < IRQ_WORD);
  assign w_is_irq = (w_word == IRQ_WORD);
  assign w_wr     = reg_valid_i & reg_write_i;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      w_sel[c]     = w_in_ch && (w_word[WA-1:2] == (WA-2)'(c));
      w_ctrl_wr[c] = w_wr && w_sel[c] && (w_off == OFF_CTRL) && reg_wstrb_i[0];
      w_thr_wr[c]  = w_wr && w_sel[c] && (w_off == OFF_THR);
      w_w1c[c]     = w_wr && w_sel[c] && (w_off == OFF_STATUS) && reg_wstrb_i[0] && reg_wdata_i[0];
      w_hit[c]     = en_q[c] && (value_q[c] == thr_q[c]);
    end
  end

  always_comb begin
    value_d = value_q;
    thr_d   = thr_q;
    en_d    = en_q;
    os_d    = os_q;
    ie_d    = ie_q;
    tc_d    = tc_q;
    pulse_d = '0;
    for (int c = 0; c < NCH; c++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_thr_wr[c] && reg_wstrb_i[i/8]) thr_d[c][i] = reg_wdata_i[i];
      end
      if (w_ctrl_wr[c] && reg_wdata_i[1]) begin
        value_d[c] = '0;
        tc_d[c]    = 1'b0;
      end else begin
        pulse_d[c] = w_hit[c];
        if (w_hit[c]) begin
          // A terminal count sets TC even if software clears it in the same cycle
          tc_d[c] = 1'b1;
          if (os_q[c]) en_d[c] = 1'b0;
          else         value_d[c] = '0;
        end else begin
          if (w_w1c[c]) tc_d[c] = 1'b0;
          if (en_q[c])  value_d[c] = value_q[c] + WIDTH'(1);
        end
      end
      // Applied last so a software CTRL write overrides the one-shot auto-disable
      if (w_ctrl_wr[c]) begin
        en_d[c] = reg_wdata_i[0];
        os_d[c] = reg_wdata_i[2];
        ie_d[c] = reg_wdata_i[3];
      end
    end
  end

  always_comb begin
    reg_rdata_o = '0;
    reg_error_o = 1'b0;
    if (reg_valid_i) begin
      if (w_in_ch) begin
        for (int c = 0; c < NCH; c++) begin
          if (w_sel[c]) begin
            case (w_off)
              OFF_CTRL:  reg_rdata_o = {28'd0, ie_q[c], os_q[c], 1'b0, en_q[c]};
              OFF_THR:   reg_rdata_o = 32'(thr_q[c]);
              OFF_VALUE: reg_rdata_o = 32'(value_q[c]);
              default:   reg_rdata_o = {31'd0, tc_q[c]};
            endcase
          end
        end
      end else if (w_is_irq) begin
        reg_rdata_o = 32'(tc_q & ie_q);
      end else begin
        reg_error_o = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
      thr_q   <= '1;
      en_q    <= '0;
      os_q    <= '0;
      ie_q    <= '0;
      tc_q    <= '0;
      pulse_q <= '0;
    end else begin
      value_q <= value_d;
      thr_q   <= thr_d;
      en_q    <= en_d;
      os_q    <= os_d;
      ie_q    <= ie_d;
      tc_q    <= tc_d;
      pulse_q <= pulse_d;
    end
  end

  assign cnt_value_o = value_q;
  assign tc_pulse_o  = pulse_q;
  assign irq_o       = |(tc_q & ie_q);
  assign reg_ready_o = 1'b1;

endmodule

`default_nettype wire
